// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one ALU between two requesters
//
// Purpose: two requesters share one combinational ALU (ADD/SUB/AND/ORR). At
// most one operation is accepted per cycle. Each result and its NZCV flags are
// registered into a single-entry, back-pressured response buffer. Accepted
// operations that have set_flags high also update an architectural flags
// register.
//
// Ports:
//   CLK, Reset                   clock (rising edge), async active-high reset
//   reqN_valid / reqN_ready      request handshake, N = 0, 1
//   reqN_src_a / reqN_src_b      operands
//   reqN_ctrl                    00 ADD, 01 SUB, 10 AND, 11 ORR
//   reqN_set_flags               update cur_flags when the operation is accepted
//   rsp_valid / rsp_ready        response handshake
//   rsp_id, rsp_result, rsp_flags  issuing requester, result, {N,Z,C,V}
//   cur_flags                    architectural flags register
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int ID_W  = 1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_src_a,
   input  logic [WIDTH-1:0] req0_src_b,
   input  logic [1:0]       req0_ctrl,
   input  logic             req0_set_flags,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_src_a,
   input  logic [WIDTH-1:0] req1_src_b,
   input  logic [1:0]       req1_ctrl,
   input  logic             req1_set_flags,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [ID_W-1:0]  rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic [3:0]       rsp_flags,
   output logic [3:0]       cur_flags
);

   // last_q = 1 means requester 1 was granted most recently; the reset value
   // of 1 lets requester 0 win the first contention.
   logic             last_q, last_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic [3:0]       cur_flags_q, cur_flags_d;

   logic             grant0, grant1, slot_free, accept;
   logic [WIDTH-1:0] alu_a, alu_b, alu_res;
   logic [1:0]       alu_op;
   logic             alu_sf, alu_c, alu_v;
   logic [WIDTH:0]   alu_sum;
   logic [3:0]       alu_flags;

   // Buffer can take a new result if empty or being drained this cycle.
   assign slot_free = !rsp_valid_q || rsp_ready;

   assign grant0 = req0_valid && (!req1_valid || last_q);
   assign grant1 = req1_valid && (!req0_valid || !last_q);

   assign req0_ready = grant0 && slot_free;
   assign req1_ready = grant1 && slot_free;
   assign accept     = req0_ready || req1_ready;

   // Operand mux defaults to requester 0 when nothing is granted.
   assign alu_a  = grant1 ? req1_src_a     : req0_src_a;
   assign alu_b  = grant1 ? req1_src_b     : req0_src_b;
   assign alu_op = grant1 ? req1_ctrl      : req0_ctrl;
   assign alu_sf = grant1 ? req1_set_flags : req0_set_flags;

   always_comb begin
      alu_sum = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_op)
         2'b00: begin
            alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            alu_res = alu_sum[WIDTH-1:0];
            alu_c   = alu_sum[WIDTH];
            alu_v   = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
         end
         2'b01: begin
            // SUB as A + ~B + 1, so C=1 means no borrow.
            alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, 1'b1};
            alu_res = alu_sum[WIDTH-1:0];
            alu_c   = alu_sum[WIDTH];
            alu_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]);
         end
         2'b10: alu_res = alu_a & alu_b;
         default: alu_res = alu_a | alu_b;
      endcase
      alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
   end

   always_comb begin
      last_d       = last_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      cur_flags_d  = cur_flags_q;
      if (accept) begin
         last_d       = grant1;
         rsp_valid_d  = 1'b1;
         rsp_id_d     = grant1 ? ID_W'(1) : '0;
         rsp_result_d = alu_res;
         rsp_flags_d  = alu_flags;
         if (alu_sf) begin
            cur_flags_d = alu_flags;
         end
      end else if (slot_free) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         last_q       <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_flags_q  <= '0;
         cur_flags_q  <= '0;
      end else begin
         last_q       <= last_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         cur_flags_q  <= cur_flags_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flags  = rsp_flags_q;
   assign cur_flags  = cur_flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        req0_valid, req0_ready, req0_set_flags;
   logic [31:0] req0_src_a, req0_src_b;
   logic [1:0]  req0_ctrl;
   logic        req1_valid, req1_ready, req1_set_flags;
   logic [31:0] req1_src_a, req1_src_b;
   logic [1:0]  req1_ctrl;
   logic        rsp_valid, rsp_ready;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_flags, cur_flags;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.WIDTH(32), .ID_W(1)) dut (
      .CLK(CLK), .Reset(Reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_src_a(req0_src_a),
      .req0_src_b(req0_src_b), .req0_ctrl(req0_ctrl), .req0_set_flags(req0_set_flags),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_src_a(req1_src_a),
      .req1_src_b(req1_src_b), .req1_ctrl(req1_ctrl), .req1_set_flags(req1_set_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .cur_flags(cur_flags)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from arithmetic definitions: carry as unsigned range,
   // overflow as signed range, borrow as an unsigned comparison.
   task automatic ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f);
      longint ua, ub, sa, sb, s;
      logic c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      case (op)
         2'd0: begin
            r = a + b;
            c = (ua + ub) > 64'sd4294967295;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         2'd1: begin
            r = a - b;
            c = (ua >= ub);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
      f = {r[31], (r == 32'd0), c, v};
   endtask

   // Model state: what the outputs must be at the next sample point.
   logic        m_valid;
   int          m_id;
   logic [31:0] m_result;
   logic [3:0]  m_flags, m_cur;
   int          m_last;

   initial begin
      logic        held0, held1;
      logic [66:0] hold0, hold1;
      int          g;
      logic        slot;
      logic [31:0] r;
      logic [3:0]  f;
      held0 = 1'b0;
      held1 = 1'b0;
      hold0 = '0;
      hold1 = '0;
      forever begin
         @(negedge CLK);
         if (Reset) begin
            m_valid  = 1'b0;
            m_id     = 0;
            m_result = '0;
            m_flags  = '0;
            m_cur    = '0;
            m_last   = 1;
            held0    = 1'b0;
            held1    = 1'b0;
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_rsp_result", rsp_result, 32'd0);
            chk("rst_cur_flags", 32'(cur_flags), 32'd0);
         end else begin
            chk("m_rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("m_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("m_rsp_result", rsp_result, m_result);
            chk("m_rsp_flags", 32'(rsp_flags), 32'(m_flags));
            chk("m_cur_flags", 32'(cur_flags), 32'(m_cur));

            slot = !m_valid || rsp_ready;
            if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            else                          g = -1;
            chk("m_req0_ready", 32'(req0_ready), 32'(slot && g == 0));
            chk("m_req1_ready", 32'(req1_ready), 32'(slot && g == 1));

            if (held0 && req0_valid)
               chk("proto_req0_stable", 32'(hold0 == {req0_src_a, req0_src_b, req0_ctrl, req0_set_flags}), 32'd1);
            if (held1 && req1_valid)
               chk("proto_req1_stable", 32'(hold1 == {req1_src_a, req1_src_b, req1_ctrl, req1_set_flags}), 32'd1);
            held0 = req0_valid && !(slot && g == 0);
            held1 = req1_valid && !(slot && g == 1);
            hold0 = {req0_src_a, req0_src_b, req0_ctrl, req0_set_flags};
            hold1 = {req1_src_a, req1_src_b, req1_ctrl, req1_set_flags};

            if (slot && g >= 0) begin
               if (g == 0) ref_alu(req0_ctrl, req0_src_a, req0_src_b, r, f);
               else        ref_alu(req1_ctrl, req1_src_a, req1_src_b, r, f);
               m_valid  = 1'b1;
               m_id     = g;
               m_result = r;
               m_flags  = f;
               if ((g == 0) ? req0_set_flags : req1_set_flags) m_cur = f;
               m_last   = g;
            end else if (slot) begin
               m_valid = 1'b0;
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic sf);
      req0_valid = v; req0_src_a = a; req0_src_b = b; req0_ctrl = op; req0_set_flags = sf;
   endtask

   task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input logic sf);
      req1_valid = v; req1_src_a = a; req1_src_b = b; req1_ctrl = op; req1_set_flags = sf;
   endtask

   initial begin
      Reset = 1'b1;
      rsp_ready = 1'b1;
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set1(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();
      step();
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_cur_flags", 32'(cur_flags), 32'd0);
      Reset = 1'b0;
      step();

      // ADD wrap-around with flags
      set0(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1);
      step();
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      chk("add_valid", 32'(rsp_valid), 32'd1);
      chk("add_id", 32'(rsp_id), 32'd0);
      chk("add_result", rsp_result, 32'h0000_0000);
      chk("add_flags", 32'(rsp_flags), 32'b0110);
      chk("add_cur", 32'(cur_flags), 32'b0110);
      step();

      // SUB then signed-overflow ADD on requester 1
      set1(1'b1, 32'd5, 32'd7, 2'b01, 1'b1);
      step();
      chk("sub_result", rsp_result, 32'hFFFF_FFFE);
      chk("sub_flags", 32'(rsp_flags), 32'b1000);
      chk("sub_id", 32'(rsp_id), 32'd1);
      set1(1'b1, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
      step();
      chk("ovf_result", rsp_result, 32'h8000_0000);
      chk("ovf_flags", 32'(rsp_flags), 32'b1001);
      chk("ovf_cur_kept", 32'(cur_flags), 32'b1000);
      set1(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();

      // Round-robin contention: order must alternate starting with requester 0
      set0(1'b1, 32'd100, 32'd1, 2'b00, 1'b0);
      set1(1'b1, 32'd200, 32'd2, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rr_id", 32'(rsp_id), 32'(i % 2));
         chk("rr_valid", 32'(rsp_valid), 32'd1);
      end
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set1(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();

      // Backpressure: held result stays stable, no readies
      set0(1'b1, 32'd1, 32'd2, 2'b00, 1'b0);
      step();
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set1(1'b1, 32'd10, 32'd20, 2'b00, 1'b0);
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_result", rsp_result, 32'd3);
         chk("bp_id", 32'(rsp_id), 32'd0);
         chk("bp_ready0", 32'(req0_ready), 32'd0);
         chk("bp_ready1", 32'(req1_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_drain_accept", 32'(req1_ready), 32'd1);
      step();
      chk("bp_next_result", rsp_result, 32'd30);
      chk("bp_next_id", 32'(rsp_id), 32'd1);
      set1(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();

      // Logic operations clear C and V
      set0(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 1'b1);
      step();
      chk("and_result", rsp_result, 32'd0);
      chk("and_flags", 32'(rsp_flags), 32'b0100);
      chk("and_cur", 32'(cur_flags), 32'b0100);
      set0(1'b1, 32'h8000_0000, 32'd0, 2'b11, 1'b1);
      step();
      chk("orr_result", rsp_result, 32'h8000_0000);
      chk("orr_flags", 32'(rsp_flags), 32'b1000);
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();

      // Asynchronous reset while a response is held
      rsp_ready = 1'b0;
      set0(1'b1, 32'd1, 32'd1, 2'b00, 1'b1);
      step();
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
      #1;
      Reset = 1'b1;
      #1;
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_id", 32'(rsp_id), 32'd0);
      chk("arst_result", rsp_result, 32'd0);
      chk("arst_flags", 32'(rsp_flags), 32'd0);
      chk("arst_cur", 32'(cur_flags), 32'd0);
      step();
      Reset = 1'b0;
      rsp_ready = 1'b1;
      set0(1'b1, 32'd4, 32'd4, 2'b00, 1'b0);
      set1(1'b1, 32'd9, 32'd9, 2'b00, 1'b0);
      #1;
      chk("post_rst_ready0", 32'(req0_ready), 32'd1);
      chk("post_rst_ready1", 32'(req1_ready), 32'd0);
      step();
      chk("post_rst_id", 32'(rsp_id), 32'd0);
      chk("post_rst_result", rsp_result, 32'd8);
      set0(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      set1(1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one instance of the team's ALU module between two requesters, for example the execute stage and a multi-cycle helper unit. The block arbitrates round-robin and accepts at most one operation per cycle. It returns a registered result with its NZCV flags through a single-entry, back-pressured response buffer. It also keeps an architectural flags register that is updated by accepted operations marked set_flags.

Parameters:
- WIDTH, 32, operand and result width. Fixed to 32 to match the ALU.
- ID_W, 1, requester-ID width (2 requesters).

Ports:
- CLK  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_src_a  in  32  operand A.
- req0_src_b  in  32  operand B.
- req0_ctrl  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- req0_set_flags  in  1  update the flags register on accept.
- req1_valid, req1_ready, req1_src_a, req1_src_b, req1_ctrl, req1_set_flags: same as req0, for requester 1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  requester that issued the result.
- rsp_result  out  32  registered ALU result.
- rsp_flags  out  4  registered {N,Z,C,V} of that operation.
- cur_flags  out  4  architectural flags register.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, cur_flags=0.
  - Round-robin pointer set so requester 0 wins the first contention.
  - Any in-flight response is discarded.
- slot_free = !rsp_valid || rsp_ready. A drain and an accept in the same cycle are allowed, giving full throughput of 1 op/cycle.
- Grant logic, combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Neither valid: no grant.
- reqN_ready = grantN && slot_free. The ready is never asserted to a requester that is not valid.
- The ALU operands are muxed from the granted requester. When nothing is granted, the mux drives requester 0's inputs (don't-care; nothing is captured).
- Accept condition: reqN_valid && reqN_ready. On the accepting clock edge:
  - rsp_result <= ALU result.
  - rsp_flags <= ALU flags.
  - rsp_id <= N.
  - rsp_valid <= 1.
  - The pointer records N as last granted.
- Latency: accept at edge k, so rsp_valid is high after edge k. The result is visible in the cycle following acceptance.
- No accept while slot_free: rsp_valid <= 0 if rsp_ready was high, otherwise unchanged.
- While rsp_valid && !rsp_ready, all rsp_* outputs hold stable. No accept occurs and both readies are low.
- Flags register: on accept with set_flags=1, cur_flags <= ALU flags on the same edge as the response. With set_flags=0, cur_flags is unchanged.
- Flag semantics, inherited from the ALU:
  - N = result[31]; Z = result == 0.
  - C = carry-out for ADD; for SUB, C = carry-out of A + ~B + 1 (so C=1 means no borrow).
  - V = signed overflow for ADD/SUB.
  - C = V = 0 for AND/ORR.
- Pointer updates only on accept. A requester that drops valid without being accepted does not move the pointer.
- Protocol rule: a requester must hold its inputs stable while valid && !ready. The bench asserts this; the block does not check it.
- Starvation bound: a continuously valid requester is accepted within 2 accepts.

Test Plan:
- ADD pass-through: req0 ADD 0xFFFFFFFF + 0x00000001, set_flags=1, rsp_ready=1.
  -> 1 cycle later rsp_valid=1, rsp_id=0, rsp_result=0x00000000, rsp_flags=0110, cur_flags=0110.
- SUB and overflow on requester 1:
  - req1 SUB 5 - 7 -> rsp_result=0xFFFFFFFE, flags 1000.
  - Then req1 ADD 0x7FFFFFFF + 1, set_flags=0 -> rsp_result=0x80000000, flags 1001; cur_flags unchanged.
- Round-robin contention: both valid continuously for 4 cycles with rsp_ready=1.
  -> accepted order id 0,1,0,1, one per cycle, and readies are never both high.
- Backpressure: hold rsp_ready=0 after the first accept for 3 cycles.
  -> rsp_* stable and both readies low. Raising rsp_ready drains the held result and accepts the next request in the same cycle.
- Logic ops: req0 AND 0xF0F0F0F0 & 0x0F0F0F0F, set_flags=1 -> result 0, flags 0100.
  - Then ORR 0x80000000 | 0 -> result 0x80000000, flags 1000.
- Reset mid-operation: assert Reset asynchronously while rsp_valid=1 and rsp_ready=0.
  -> all outputs 0 immediately, without waiting for a clock edge.
  -> after release with both requesters valid, requester 0 is granted first.
